// File: rtl/h264_pkg.sv
// Shared definitions for the H.264 front-end blocks: macroblock geometry,
// the default pixel type and a counter-width helper.
package h264_pkg;

    localparam int MB_SIZE     = 16;
    localparam int PIXEL_W_DEF = 24;

    typedef logic [PIXEL_W_DEF-1:0] pixel_t;

    // Width of a counter spanning 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mb_band_ram.sv
// Simple dual-port storage for the two ping-pong bands. The read port is
// registered and holds its data whenever rd_en is low, so it can stall.
module mb_band_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/macroblock_raster.sv
// Converts 16x16 macroblock-ordered pixels to raster order through a
// two-band ping-pong buffer. Optional frame counter: MB_RASTER_FRAME_CNT_EN.
module macroblock_raster
    import h264_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int PIXEL_W      = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               sof_out,
    output logic               eol_out
`ifdef MB_RASTER_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_count
`endif
);

    localparam int MBX     = FRAME_WIDTH / MB_SIZE;
    localparam int NBANDS  = FRAME_HEIGHT / MB_SIZE;
    localparam int BAND_SZ = MB_SIZE * FRAME_WIDTH;
    localparam int DEPTH   = 2 * BAND_SZ;
    localparam int AW      = $clog2(DEPTH);
    localparam int SW      = $clog2(MB_SIZE);
    localparam int MW      = cnt_w(MBX);
    localparam int BW      = cnt_w(NBANDS);
    localparam int XW      = cnt_w(FRAME_WIDTH);

    logic [SW-1:0] wr_col_q, wr_col_d, wr_row_q, wr_row_d;
    logic [MW-1:0] wr_mbx_q, wr_mbx_d;
    logic          wb_q, wb_d;
    logic [1:0]    full_q, full_d;
    logic [XW-1:0] rd_x_q, rd_x_d;
    logic [SW-1:0] rd_line_q, rd_line_d;
    logic [BW-1:0] rd_band_q, rd_band_d;
    logic          rb_q, rb_d;
    logic          s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;
    logic          s1_blast_q, s1_blast_d, s1_band_q, s1_band_d;
    logic          valid_out_q, valid_out_d, sof_q, sof_d, eol_q, eol_d;
    logic          out_blast_q, out_blast_d, out_band_q, out_band_d;
    logic [PIXEL_W-1:0] pixel_out_q, pixel_out_d, ram_rd_data;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_fire, wr_band_end, rd_fire, adv_out, out_fire;
    logic          col_end, row_end, mbx_end, x_end, line_end, band_end;

    assign ready_out = !full_q[wb_q];
    assign valid_out = valid_out_q;
    assign pixel_out = pixel_out_q;
    assign sof_out   = sof_q;
    assign eol_out   = eol_q;

    always_comb begin
        col_end  = wr_col_q == SW'(MB_SIZE - 1);
        row_end  = wr_row_q == SW'(MB_SIZE - 1);
        mbx_end  = wr_mbx_q == MW'(MBX - 1);
        x_end    = rd_x_q == XW'(FRAME_WIDTH - 1);
        line_end = rd_line_q == SW'(MB_SIZE - 1);
        band_end = rd_band_q == BW'(NBANDS - 1);

        wr_fire     = valid_in && !full_q[wb_q];
        wr_band_end = wr_fire && col_end && row_end && mbx_end;
        adv_out     = !valid_out_q || ready_in;
        out_fire    = valid_out_q && ready_in;
        // Only issue a RAM read when stage 1 is free or draining, so the
        // held RAM output always matches the pixel waiting in stage 1.
        rd_fire     = full_q[rb_q] && (!s1_valid_q || adv_out);

        wr_addr = (wb_q ? AW'(BAND_SZ) : '0) + AW'(wr_row_q) * AW'(FRAME_WIDTH)
                + AW'(wr_mbx_q) * AW'(MB_SIZE) + AW'(wr_col_q);
        rd_addr = (rb_q ? AW'(BAND_SZ) : '0) + AW'(rd_line_q) * AW'(FRAME_WIDTH)
                + AW'(rd_x_q);

        wr_col_d = wr_col_q;
        wr_row_d = wr_row_q;
        wr_mbx_d = wr_mbx_q;
        wb_d     = wb_q;
        if (wr_fire) begin
            wr_col_d = col_end ? '0 : wr_col_q + 1'b1;
            if (col_end) begin
                wr_row_d = row_end ? '0 : wr_row_q + 1'b1;
                if (row_end) begin
                    wr_mbx_d = mbx_end ? '0 : wr_mbx_q + 1'b1;
                    if (mbx_end) wb_d = !wb_q;
                end
            end
        end

        rd_x_d    = rd_x_q;
        rd_line_d = rd_line_q;
        rd_band_d = rd_band_q;
        rb_d      = rb_q;
        if (rd_fire) begin
            rd_x_d = x_end ? '0 : rd_x_q + 1'b1;
            if (x_end) begin
                rd_line_d = line_end ? '0 : rd_line_q + 1'b1;
                if (line_end) begin
                    rb_d      = !rb_q;
                    rd_band_d = band_end ? '0 : rd_band_q + 1'b1;
                end
            end
        end

        s1_valid_d = s1_valid_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        s1_blast_d = s1_blast_q;
        s1_band_d  = s1_band_q;
        if (rd_fire) begin
            s1_valid_d = 1'b1;
            s1_sof_d   = (rd_x_q == '0) && (rd_line_q == '0) && (rd_band_q == '0);
            s1_eol_d   = x_end;
            s1_blast_d = x_end && line_end;
            s1_band_d  = rb_q;
        end else if (adv_out) begin
            s1_valid_d = 1'b0;
        end

        valid_out_d = valid_out_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        out_blast_d = out_blast_q;
        out_band_d  = out_band_q;
        pixel_out_d = pixel_out_q;
        if (adv_out) begin
            valid_out_d = s1_valid_q;
            sof_d       = s1_valid_q && s1_sof_q;
            eol_d       = s1_valid_q && s1_eol_q;
            out_blast_d = s1_valid_q && s1_blast_q;
            out_band_d  = s1_band_q;
            if (s1_valid_q) pixel_out_d = ram_rd_data;
        end

        // Set and clear always address different bands, so both apply.
        full_d = full_q;
        if (wr_band_end) full_d[wb_q] = 1'b1;
        if (out_fire && out_blast_q) full_d[out_band_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_col_q <= '0; wr_row_q <= '0; wr_mbx_q <= '0; wb_q <= 1'b0;
            full_q <= '0;
            rd_x_q <= '0; rd_line_q <= '0; rd_band_q <= '0; rb_q <= 1'b0;
            s1_valid_q <= 1'b0; s1_sof_q <= 1'b0; s1_eol_q <= 1'b0;
            s1_blast_q <= 1'b0; s1_band_q <= 1'b0;
            valid_out_q <= 1'b0; sof_q <= 1'b0; eol_q <= 1'b0;
            out_blast_q <= 1'b0; out_band_q <= 1'b0; pixel_out_q <= '0;
        end else begin
            wr_col_q <= wr_col_d; wr_row_q <= wr_row_d; wr_mbx_q <= wr_mbx_d; wb_q <= wb_d;
            full_q <= full_d;
            rd_x_q <= rd_x_d; rd_line_q <= rd_line_d; rd_band_q <= rd_band_d; rb_q <= rb_d;
            s1_valid_q <= s1_valid_d; s1_sof_q <= s1_sof_d; s1_eol_q <= s1_eol_d;
            s1_blast_q <= s1_blast_d; s1_band_q <= s1_band_d;
            valid_out_q <= valid_out_d; sof_q <= sof_d; eol_q <= eol_d;
            out_blast_q <= out_blast_d; out_band_q <= out_band_d; pixel_out_q <= pixel_out_d;
        end
    end

`ifdef MB_RASTER_FRAME_CNT_EN
    logic        s1_flast_q, s1_flast_d, out_flast_q, out_flast_d;
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        s1_flast_d    = s1_flast_q;
        out_flast_d   = out_flast_q;
        frame_count_d = frame_count_q;
        if (rd_fire) s1_flast_d = x_end && line_end && band_end;
        if (adv_out) out_flast_d = s1_valid_q && s1_flast_q;
        if (out_fire && out_flast_q) frame_count_d = frame_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_flast_q    <= 1'b0;
            out_flast_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            s1_flast_q    <= s1_flast_d;
            out_flast_q   <= out_flast_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

    mb_band_ram #(
        .DATA_W (PIXEL_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (pixel_in),
        .rd_en   (rd_fire),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule
